branch_resolve_queue: RTL and testbench

- Resolution-side partner of the branch history table.
- Fetch records each predicted branch: 5-bit table index, predicted direction, predicted target, fall-through PC. Records sit in order in a small FIFO.
- When execute resolves the oldest branch, the block drives the history-table update strobe, index and direction. It also detects mispredictions, issues a redirect PC, flushes wrong-path entries and keeps statistics counters.

---
 rtl/branch_resolve_queue.sv | 140 ++++++++++++++
 tb/tb_branch_resolve_queue.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_queue.sv
// branch_resolve_queue: in-order FIFO of predicted branches from fetch.
// When execute resolves the oldest entry this block trains the branch
// history table, detects mispredictions, issues a redirect PC, flushes
// wrong-path entries and keeps saturating statistics counters.
//
// Handshake: push and resolve_valid are single-cycle qualifiers with no
// ready return. full/empty are advisory status; a push while full (without
// a same-cycle pop) is dropped and flagged in sticky overflow, and a resolve
// while empty is ignored and flagged in sticky underflow. update and
// mispredict are one-cycle strobes, one cycle after the resolve edge.
module branch_resolve_queue #(
  parameter int DEPTH  = 4,
  parameter int IDX_W  = 5,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [IDX_W-1:0]  push_idx,
  input  logic              push_pred_taken,
  input  logic [ADDR_W-1:0] push_target,
  input  logic [ADDR_W-1:0] push_fallthrough,
  output logic              full,
  output logic              empty,
  input  logic              resolve_valid,
  input  logic              resolve_taken,
  input  logic [ADDR_W-1:0] resolve_target,
  output logic              update,
  output logic [IDX_W-1:0]  update_idx,
  output logic              update_direction,
  output logic              mispredict,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic [31:0]       branch_count,
  output logic [31:0]       mispredict_count,
  output logic              overflow,
  output logic              underflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);

  logic [IDX_W-1:0]  idx_mem  [DEPTH];
  logic              pred_mem [DEPTH];
  logic [ADDR_W-1:0] tgt_mem  [DEPTH];
  logic [ADDR_W-1:0] ft_mem   [DEPTH];

  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W:0]   count;

  logic              head_pred;
  logic [IDX_W-1:0]  head_idx;
  logic [ADDR_W-1:0] head_tgt;
  logic [ADDR_W-1:0] head_ft;
  logic              do_pop;
  logic              mispred_now;
  logic              has_room;
  logic              do_push;
  logic              push_drop;

  assign full  = (count == CNT_FULL);
  assign empty = (count == '0);

  assign head_pred = pred_mem[rd_ptr];
  assign head_idx  = idx_mem[rd_ptr];
  assign head_tgt  = tgt_mem[rd_ptr];
  assign head_ft   = ft_mem[rd_ptr];

  // Decode this cycle's pop, misprediction and push acceptance.
  always_comb begin
    do_pop      = resolve_valid && !empty;
    mispred_now = do_pop &&
                  ((resolve_taken != head_pred) ||
                   (resolve_taken && head_pred && (resolve_target != head_tgt)));
    has_room    = !full || do_pop;
    // A push alongside a misprediction is wrong-path: discarded, not an overflow.
    do_push     = push && has_room && !mispred_now;
    push_drop   = push && !has_room;
  end

  // Entry storage: written on accepted pushes only, no reset needed.
  always_ff @(posedge clk) begin
    if (do_push && !rst) begin
      idx_mem[wr_ptr]  <= push_idx;
      pred_mem[wr_ptr] <= push_pred_taken;
      tgt_mem[wr_ptr]  <= push_target;
      ft_mem[wr_ptr]   <= push_fallthrough;
    end
  end

  // Pointers, occupancy, flush, strobes, training outputs and statistics.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr           <= '0;
      wr_ptr           <= '0;
      count            <= '0;
      update           <= 1'b0;
      update_idx       <= '0;
      update_direction <= 1'b0;
      mispredict       <= 1'b0;
      redirect_pc      <= '0;
      branch_count     <= '0;
      mispredict_count <= '0;
      overflow         <= 1'b0;
      underflow        <= 1'b0;
    end else begin
      update     <= do_pop;
      mispredict <= mispred_now;

      if (do_pop) begin
        update_idx       <= head_idx;
        update_direction <= resolve_taken;
        if (branch_count != '1) branch_count <= branch_count + 32'd1;
      end

      if (mispred_now) begin
        redirect_pc <= resolve_taken ? resolve_target : head_ft;
        if (mispredict_count != '1) mispredict_count <= mispredict_count + 32'd1;
      end

      if (push_drop)                overflow  <= 1'b1;
      if (resolve_valid && empty)   underflow <= 1'b1;

      if (mispred_now) begin
        // Everything younger than the mispredicted branch is wrong-path.
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
        if (do_push && !do_pop)      count <= count + CNT_ONE;
        else if (do_pop && !do_push) count <= count - CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Directed table-driven bench for branch_resolve_queue plus hand-written
// sequences for flush, underflow and mid-operation reset.
module tb_branch_resolve_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        push;
  logic [4:0]  push_idx;
  logic        push_pred_taken;
  logic [31:0] push_target;
  logic [31:0] push_fallthrough;
  logic        full;
  logic        empty;
  logic        resolve_valid;
  logic        resolve_taken;
  logic [31:0] resolve_target;
  logic        update;
  logic [4:0]  update_idx;
  logic        update_direction;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic [31:0] branch_count;
  logic [31:0] mispredict_count;
  logic        overflow;
  logic        underflow;

  int n_cmp = 0;
  int n_bad = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  branch_resolve_queue #(.DEPTH(4), .IDX_W(5), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .push(push), .push_idx(push_idx), .push_pred_taken(push_pred_taken),
    .push_target(push_target), .push_fallthrough(push_fallthrough),
    .full(full), .empty(empty),
    .resolve_valid(resolve_valid), .resolve_taken(resolve_taken),
    .resolve_target(resolve_target),
    .update(update), .update_idx(update_idx), .update_direction(update_direction),
    .mispredict(mispredict), .redirect_pc(redirect_pc),
    .branch_count(branch_count), .mispredict_count(mispredict_count),
    .overflow(overflow), .underflow(underflow)
  );

  // ---------------- vector table ----------------
  typedef struct {
    logic [31:0] push, idx, pred, tgt, ft;
    logic [31:0] rv, rt, rtgt;
    logic [31:0] e_upd, e_idx, e_dir, e_mis, e_rpc;
    logic [31:0] e_bc, e_mc, e_ovf, e_emp, e_ful;
  } vec_t;

  vec_t vecs[16];

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    push = 1'b0; push_idx = '0; push_pred_taken = 1'b0;
    push_target = '0; push_fallthrough = '0;
    resolve_valid = 1'b0; resolve_taken = 1'b0; resolve_target = '0;
  endtask

  task automatic drive_push(input logic [4:0] idx, input logic pred,
                            input logic [31:0] tgt, input logic [31:0] ft);
    push = 1'b1; push_idx = idx; push_pred_taken = pred;
    push_target = tgt; push_fallthrough = ft;
  endtask

  task automatic drive_resolve(input logic taken, input logic [31:0] tgt);
    resolve_valid = 1'b1; resolve_taken = taken; resolve_target = tgt;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  // ---------------- scoreboard check ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  initial begin
    vecs[0]  = '{1, 3, 1, 'h100, 'h24,  0, 0, 0,      0, 0, 0, 0, 0,      0, 0, 0, 0, 0};
    vecs[1]  = '{0, 0, 0, 0, 0,         1, 1, 'h100,  1, 3, 1, 0, 0,      1, 0, 0, 1, 0};
    vecs[2]  = '{1, 7, 0, 0, 'h40,      0, 0, 0,      0, 0, 0, 0, 0,      1, 0, 0, 0, 0};
    vecs[3]  = '{0, 0, 0, 0, 0,         1, 1, 'h80,   1, 7, 1, 1, 'h80,   2, 1, 0, 1, 0};
    vecs[4]  = '{1, 1, 0, 0, 'h14,      0, 0, 0,      0, 0, 0, 0, 0,      2, 1, 0, 0, 0};
    vecs[5]  = '{1, 2, 1, 'h300, 'h18,  0, 0, 0,      0, 0, 0, 0, 0,      2, 1, 0, 0, 0};
    vecs[6]  = '{1, 4, 0, 0, 'h1c,      0, 0, 0,      0, 0, 0, 0, 0,      2, 1, 0, 0, 0};
    vecs[7]  = '{1, 5, 1, 'h500, 'h20,  0, 0, 0,      0, 0, 0, 0, 0,      2, 1, 0, 0, 1};
    vecs[8]  = '{1, 6, 0, 0, 'h2c,      0, 0, 0,      0, 0, 0, 0, 0,      2, 1, 1, 0, 1};
    vecs[9]  = '{1, 8, 0, 0, 'h30,      1, 0, 0,      1, 1, 0, 0, 0,      3, 1, 1, 0, 1};
    vecs[10] = '{0, 0, 0, 0, 0,         1, 0, 'h999,  1, 2, 0, 1, 'h18,   4, 2, 1, 1, 0};
    vecs[11] = '{0, 0, 0, 0, 0,         0, 0, 0,      0, 0, 0, 0, 0,      4, 2, 1, 1, 0};
    vecs[12] = '{1, 9, 1, 'h40, 'h44,   0, 0, 0,      0, 0, 0, 0, 0,      4, 2, 1, 0, 0};
    vecs[13] = '{1, 10, 0, 0, 'h48,     0, 0, 0,      0, 0, 0, 0, 0,      4, 2, 1, 0, 0};
    vecs[14] = '{0, 0, 0, 0, 0,         1, 1, 'h40,   1, 9, 1, 0, 0,      5, 2, 1, 0, 0};
    vecs[15] = '{0, 0, 0, 0, 0,         1, 0, 0,      1, 10, 0, 0, 0,     6, 2, 1, 1, 0};

    rst = 1'b0;
    idle_inputs();
    do_reset();

    // Reset state.
    chk("rst_update", {31'd0, update}, 0);
    chk("rst_mispredict", {31'd0, mispredict}, 0);
    chk("rst_update_idx", {27'd0, update_idx}, 0);
    chk("rst_update_dir", {31'd0, update_direction}, 0);
    chk("rst_redirect_pc", redirect_pc, 0);
    chk("rst_branch_count", branch_count, 0);
    chk("rst_mispredict_count", mispredict_count, 0);
    chk("rst_overflow", {31'd0, overflow}, 0);
    chk("rst_underflow", {31'd0, underflow}, 0);
    chk("rst_empty", {31'd0, empty}, 1);
    chk("rst_full", {31'd0, full}, 0);

    // Table: one cycle per vector, outputs checked just after the edge.
    for (int i = 0; i < 16; i++) begin
      push             = vecs[i].push[0];
      push_idx         = vecs[i].idx[4:0];
      push_pred_taken  = vecs[i].pred[0];
      push_target      = vecs[i].tgt;
      push_fallthrough = vecs[i].ft;
      resolve_valid    = vecs[i].rv[0];
      resolve_taken    = vecs[i].rt[0];
      resolve_target   = vecs[i].rtgt;
      step();
      idle_inputs();
      chk($sformatf("v%0d_update", i), {31'd0, update}, vecs[i].e_upd);
      chk($sformatf("v%0d_mispredict", i), {31'd0, mispredict}, vecs[i].e_mis);
      if (vecs[i].e_upd[0]) begin
        chk($sformatf("v%0d_update_idx", i), {27'd0, update_idx}, vecs[i].e_idx);
        chk($sformatf("v%0d_update_dir", i), {31'd0, update_direction}, vecs[i].e_dir);
      end
      if (vecs[i].e_mis[0])
        chk($sformatf("v%0d_redirect_pc", i), redirect_pc, vecs[i].e_rpc);
      chk($sformatf("v%0d_branch_count", i), branch_count, vecs[i].e_bc);
      chk($sformatf("v%0d_mispredict_count", i), mispredict_count, vecs[i].e_mc);
      chk($sformatf("v%0d_overflow", i), {31'd0, overflow}, vecs[i].e_ovf);
      chk($sformatf("v%0d_underflow", i), {31'd0, underflow}, 0);
      chk($sformatf("v%0d_empty", i), {31'd0, empty}, vecs[i].e_emp);
      chk($sformatf("v%0d_full", i), {31'd0, full}, vecs[i].e_ful);
    end

    // Flush: taken/taken with wrong target while a 4th push arrives.
    do_reset();
    drive_push(5'd11, 1'b1, 32'h200, 32'h208); step();
    drive_push(5'd12, 1'b0, 32'h0,   32'h20c); step();
    drive_push(5'd13, 1'b1, 32'h600, 32'h210); step();
    idle_inputs();
    drive_push(5'd14, 1'b0, 32'h0, 32'h214);
    drive_resolve(1'b1, 32'h204);
    step();
    idle_inputs();
    chk("flush_mispredict", {31'd0, mispredict}, 1);
    chk("flush_update", {31'd0, update}, 1);
    chk("flush_update_idx", {27'd0, update_idx}, 11);
    chk("flush_redirect_pc", redirect_pc, 32'h204);
    chk("flush_empty", {31'd0, empty}, 1);
    chk("flush_overflow", {31'd0, overflow}, 0);
    chk("flush_mispredict_count", mispredict_count, 1);
    step();
    chk("flush_strobe_drop", {31'd0, mispredict}, 0);
    chk("flush_still_empty", {31'd0, empty}, 1);
    chk("flush_redirect_hold", redirect_pc, 32'h204);

    // Underflow: resolve while empty has no side effects besides the flag.
    drive_resolve(1'b1, 32'h40);
    step();
    idle_inputs();
    chk("unf_flag", {31'd0, underflow}, 1);
    chk("unf_update", {31'd0, update}, 0);
    chk("unf_mispredict", {31'd0, mispredict}, 0);
    chk("unf_branch_count", branch_count, 1);
    chk("unf_mispredict_count", mispredict_count, 1);
    chk("unf_empty", {31'd0, empty}, 1);

    // Reset in the same cycle as a resolve suppresses the strobe.
    drive_push(5'd20, 1'b1, 32'h700, 32'h704); step();
    drive_push(5'd21, 1'b0, 32'h0,   32'h708); step();
    idle_inputs();
    chk("prerst_empty", {31'd0, empty}, 0);
    drive_resolve(1'b0, 32'h0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    idle_inputs();
    chk("midrst_update", {31'd0, update}, 0);
    chk("midrst_mispredict", {31'd0, mispredict}, 0);
    chk("midrst_empty", {31'd0, empty}, 1);
    chk("midrst_branch_count", branch_count, 0);
    chk("midrst_mispredict_count", mispredict_count, 0);
    chk("midrst_underflow", {31'd0, underflow}, 0);
    chk("midrst_redirect_pc", redirect_pc, 0);
    step();
    chk("postrst_update", {31'd0, update}, 0);
    chk("postrst_empty", {31'd0, empty}, 1);

    // Final report.
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
